// File: rtl/bus_arb_pkg.sv
// Shared types and default parameter values for the output bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_N_CH          = 4;
  localparam int unsigned DEF_BUS_W         = 512;
  localparam int unsigned DEF_BEATS_PER_PKT = 2;
  localparam int unsigned DEF_CREDITS       = 8;
  localparam int unsigned DEF_TIMEOUT       = 255;

endpackage

// File: rtl/rr_arb.sv
// Round-robin priority picker: searches from the pointer upward (wrapping)
// and advances the pointer past the winner when the grant is taken.
module rr_arb #(
  parameter int unsigned N_CH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_CH-1:0]                         i_req,
  input  logic                                    i_take,
  output logic                                    o_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_idx
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand;

  // First requesting channel at or after the pointer, modulo N_CH
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_cand = IDX_W'((32'(r_ptr) + k) % N_CH);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

  // Pointer moves to the channel after the one just granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_take && o_valid) begin
      r_ptr <= (o_idx == IDX_W'(N_CH - 1)) ? '0 : o_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/bus_out_arb.sv
// Credit-gated round-robin arbiter multiplexing N_CH decoder channels onto a
// single write bus, one whole packet per grant, with sticky error reporting.
module bus_out_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_CH          = DEF_N_CH,
  parameter int unsigned BUS_W         = DEF_BUS_W,
  parameter int unsigned BEATS_PER_PKT = DEF_BEATS_PER_PKT,
  parameter int unsigned CREDITS       = DEF_CREDITS,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                                       clk_bus,
  input  logic                                       rst_n,
  input  logic [N_CH-1:0]                            ch_req,
  output logic [N_CH-1:0]                            ch_ready,
  input  logic [N_CH-1:0]                            ch_en,
  input  logic [N_CH*BUS_W-1:0]                      ch_data,
  output logic [BUS_W-1:0]                           out_data,
  output logic                                       out_en,
  output logic                                       out_sop,
  output logic                                       out_eop,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_ch,
  input  logic                                       cred_ret,
  output logic [$clog2(CREDITS+1)-1:0]               credit_cnt,
  output logic                                       err_proto,
  output logic                                       err_timeout,
  output logic                                       err_cred
);

  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W  = $clog2(CREDITS + 1);
  localparam int unsigned BEAT_W = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  arb_state_e        r_state, w_next;
  logic [CH_W-1:0]   r_grant_idx, w_win_idx;
  logic              w_win_valid;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [CNT_W-1:0]  r_credit;
  logic [BUS_W-1:0]  r_out_data, w_sel_data;
  logic              r_out_en, r_out_sop, r_out_eop;
  logic [CH_W-1:0]   r_out_ch;
  logic              r_err_proto, r_err_timeout, r_err_cred;
  logic [N_CH-1:0]   w_ready;
  logic              w_grant, w_beat, w_last_beat, w_tmo_hit, w_stray, w_cred_full;

  rr_arb #(.N_CH(N_CH)) u_rr (
    .clk     (clk_bus),
    .rst_n   (rst_n),
    .i_req   (ch_req),
    .i_take  (w_grant),
    .o_valid (w_win_valid),
    .o_idx   (w_win_idx)
  );

  assign w_grant     = (r_state == ST_IDLE) && w_win_valid && (r_credit != '0);
  assign w_beat      = (r_state == ST_XFER) && ch_en[r_grant_idx];
  assign w_last_beat = w_beat && (r_beat_cnt == BEAT_W'(BEATS_PER_PKT - 1));
  assign w_tmo_hit   = (r_state == ST_XFER) && !w_beat && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign w_stray     = |(ch_en & ~w_ready);
  assign w_cred_full = (r_credit == CNT_W'(CREDITS));

  // FSM state register
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_next = ST_XFER;
      ST_XFER: if (w_last_beat || w_tmo_hit) w_next = ST_GAP;
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only toward the granted channel while transferring
  always_comb begin
    w_ready = '0;
    if (r_state == ST_XFER) w_ready[r_grant_idx] = 1'b1;
  end

  // Granted channel's data slice
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (r_grant_idx == CH_W'(i)) w_sel_data = ch_data[i*BUS_W +: BUS_W];
    end
  end

  // Grant latch, beat counter and idle (timeout) counter
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      if (w_grant) r_grant_idx <= w_win_idx;
      if (r_state != ST_XFER || w_next != ST_XFER) begin
        r_beat_cnt <= '0;
        r_tmo_cnt  <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
        r_tmo_cnt  <= '0;
      end else begin
        r_tmo_cnt  <= r_tmo_cnt + TMO_W'(1);
      end
    end
  end

  // One-cycle registered forwarding of accepted beats
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_en   <= 1'b0;
      r_out_sop  <= 1'b0;
      r_out_eop  <= 1'b0;
      r_out_ch   <= '0;
    end else begin
      r_out_en  <= w_beat;
      r_out_sop <= w_beat && (r_beat_cnt == '0);
      r_out_eop <= w_last_beat;
      if (w_beat) begin
        r_out_data <= w_sel_data;
        r_out_ch   <= r_grant_idx;
      end
    end
  end

  // Credit counter: a return at full scale is rejected but a grant still consumes
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= CNT_W'(CREDITS);
    end else if (cred_ret && w_cred_full) begin
      if (w_grant) r_credit <= r_credit - CNT_W'(1);
    end else if (w_grant && !cred_ret) begin
      r_credit <= r_credit - CNT_W'(1);
    end else if (cred_ret && !w_grant) begin
      r_credit <= r_credit + CNT_W'(1);
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_err_proto   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_cred    <= 1'b0;
    end else begin
      if (w_stray)                 r_err_proto   <= 1'b1;
      if (w_tmo_hit)               r_err_timeout <= 1'b1;
      if (cred_ret && w_cred_full) r_err_cred    <= 1'b1;
    end
  end

  assign ch_ready    = w_ready;
  assign out_data    = r_out_data;
  assign out_en      = r_out_en;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_ch      = r_out_ch;
  assign credit_cnt  = r_credit;
  assign err_proto   = r_err_proto;
  assign err_timeout = r_err_timeout;
  assign err_cred    = r_err_cred;

endmodule

// File: tb/tb_bus_out_arb.sv
// Bench for bus_out_arb: a channel responder answers ch_ready with beats and
// queues the expected forwarded beats; a monitor pops and compares them.
module tb_bus_out_arb;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned BW    = 64;
  localparam int unsigned BEATS = 2;
  localparam int unsigned CRED  = 8;
  localparam int unsigned TMO   = 16;

  typedef struct {
    logic [BW-1:0] data;
    logic [1:0]    ch;
    logic          sop;
    logic          eop;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   ch_req, ch_en, resp_en, man_en, ch_ready, ch_ready2, rdy_sel;
  logic [N_CH*BW-1:0] ch_data;
  logic [BW-1:0]     out_data, out_data2;
  logic              out_en, out_sop, out_eop, out_en2, out_sop2, out_eop2;
  logic [1:0]        out_ch, out_ch2;
  logic              cred_ret;
  logic [3:0]        credit_cnt;
  logic [1:0]        credit_cnt2;
  logic              err_proto, err_timeout, err_cred;
  logic              err_proto2, err_timeout2, err_cred2;

  int    checks = 0;
  int    errors = 0;
  int    eop_seen = 0;
  int    resp_limit = BEATS;
  int    seq = 0;
  int    sent [N_CH];
  bit    use_dut2 = 1'b0;
  beat_t exp_q [$];
  int    grant_q [$];

  always #5 clk = ~clk;

  assign ch_en   = resp_en | man_en;
  assign rdy_sel = use_dut2 ? ch_ready2 : ch_ready;

  bus_out_arb #(.N_CH(N_CH), .BUS_W(BW), .BEATS_PER_PKT(BEATS), .CREDITS(CRED), .TIMEOUT(TMO)) u_dut (
    .clk_bus(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_ready(ch_ready), .ch_en(ch_en),
    .ch_data(ch_data), .out_data(out_data), .out_en(out_en), .out_sop(out_sop),
    .out_eop(out_eop), .out_ch(out_ch), .cred_ret(cred_ret), .credit_cnt(credit_cnt),
    .err_proto(err_proto), .err_timeout(err_timeout), .err_cred(err_cred)
  );

  bus_out_arb #(.N_CH(N_CH), .BUS_W(BW), .BEATS_PER_PKT(BEATS), .CREDITS(2), .TIMEOUT(TMO)) u_dut2 (
    .clk_bus(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_ready(ch_ready2), .ch_en(ch_en),
    .ch_data(ch_data), .out_data(out_data2), .out_en(out_en2), .out_sop(out_sop2),
    .out_eop(out_eop2), .out_ch(out_ch2), .cred_ret(cred_ret), .credit_cnt(credit_cnt2),
    .err_proto(err_proto2), .err_timeout(err_timeout2), .err_cred(err_cred2)
  );

  // Channel responder: sends up to resp_limit beats while its ready is high
  initial begin
    logic [BW-1:0] d;
    resp_en = '0;
    ch_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) begin
        if (rdy_sel[i] && sent[i] < resp_limit) begin
          d = {16'hC000 | 16'(i), 16'(seq), 32'($urandom)};
          ch_data[i*BW +: BW] = d;
          resp_en[i] = 1'b1;
          if (!use_dut2) exp_q.push_back('{d, 2'(i), sent[i] == 0, sent[i] == BEATS - 1});
          if (sent[i] == 0) grant_q.push_back(i);
          sent[i]++;
          seq++;
        end else begin
          resp_en[i] = 1'b0;
          if (!rdy_sel[i]) sent[i] = 0;
        end
      end
    end
  end

  // Scoreboard monitor on the main DUT
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      checks++;
      if ($countones(rdy_sel) > 1) begin
        errors++;
        $display("FAIL ready_onehot: ch_ready=%b, required at most one bit", rdy_sel);
      end
      if (!use_dut2 && out_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got ch=%0d sop=%b eop=%b data=%h, required no beat",
                   out_ch, out_sop, out_eop, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_ch !== e.ch || out_sop !== e.sop || out_eop !== e.eop) begin
            errors++;
            $display("FAIL beat: got ch=%0d sop=%b eop=%b data=%h, required ch=%0d sop=%b eop=%b data=%h",
                     out_ch, out_sop, out_eop, out_data, e.ch, e.sop, e.eop, e.data);
          end
        end
        if (out_eop) eop_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    ch_req = '0; man_en = '0; cred_ret = 1'b0; resp_limit = BEATS; use_dut2 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete(); grant_q.delete(); eop_seen = 0;
  endtask

  task automatic wait_rdy(input int ch, input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (rdy_sel[ch] == lvl) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_grants(input int cnt, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (grant_q.size() >= cnt) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      quiet = (rdy_sel == '0) ? quiet + 1 : 0;
      if (quiet >= 3) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ch_ready !== '0 || out_en !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b en=%b sop=%b eop=%b, required all 0", ch_ready, out_en, out_sop, out_eop);
    end
    checks++;
    if (out_data !== '0 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h ch=%0d, required 0", out_data, out_ch);
    end
    checks++;
    if (credit_cnt !== 4'd8 || credit_cnt2 !== 2'd2) begin
      errors++;
      $display("FAIL reset_credit: got %0d/%0d, required 8/2", credit_cnt, credit_cnt2);
    end
    checks++;
    if ({err_proto, err_timeout, err_cred} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err: got %b, required 000", {err_proto, err_timeout, err_cred});
    end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    do_reset();
    ch_req = 4'b0001;
    wait_rdy(0, 1'b1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_grant: no ready, required ch_ready[0]=1"); end
    checks++;
    if (credit_cnt !== 4'd7) begin errors++; $display("FAIL single_credit: got %0d, required 7", credit_cnt); end
    wait_rdy(0, 1'b0, 10, ok);
    n = 0;
    while (!ch_ready[0] && n < 10) begin n++; @(negedge clk); end
    checks++;
    if (n != 2) begin errors++; $display("FAIL gap_len: ready low %0d cycles, required 2", n); end
    ch_req = '0;
    wait_idle(20, ok);
    checks++;
    if (!ok || eop_seen != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_done: eops=%0d pending=%0d, required 2 and 0", eop_seen, exp_q.size());
    end
    checks++;
    if (credit_cnt !== 4'd6) begin errors++; $display("FAIL single_credit2: got %0d, required 6", credit_cnt); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    ch_req = 4'b1111;
    wait_grants(5, 100, ok);
    ch_req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_grants: got %0d grants, required 5", grant_q.size()); end
    wait_idle(30, ok);
    for (int k = 0; k < 5 && k < grant_q.size(); k++) begin
      checks++;
      if (grant_q[k] != k % 4) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d", k, grant_q[k], k % 4);
      end
    end
    checks++;
    if (eop_seen != 5 || exp_q.size() != 0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL rr_done: eops=%0d pending=%0d proto=%b, required 5 0 0", eop_seen, exp_q.size(), err_proto);
    end
  endtask

  task automatic test_credit_stall();
    bit ok;
    do_reset();
    use_dut2 = 1'b1;
    ch_req = 4'b0111;
    repeat (40) @(negedge clk);
    checks++;
    if (grant_q.size() != 2 || credit_cnt2 !== 2'd0 || ch_ready2 !== '0) begin
      errors++;
      $display("FAIL stall: grants=%0d credit=%0d ready=%b, required 2 0 0000", grant_q.size(), credit_cnt2, ch_ready2);
    end
    @(posedge clk); #1 cred_ret = 1'b1;
    @(posedge clk); #1 cred_ret = 1'b0;
    wait_grants(3, 20, ok);
    checks++;
    if (!ok || grant_q[2] != 2) begin
      errors++;
      $display("FAIL stall_resume: grants=%0d, required third grant to channel 2", grant_q.size());
    end
    ch_req = '0;
    wait_idle(20, ok);
    checks++;
    if (credit_cnt2 !== 2'd0) begin errors++; $display("FAIL stall_credit: got %0d, required 0", credit_cnt2); end
    use_dut2 = 1'b0;
  endtask

  task automatic test_credit_arith();
    bit ok;
    do_reset();
    ch_req = 4'b0001;
    wait_grants(3, 60, ok);
    ch_req = '0;
    wait_idle(20, ok);
    checks++;
    if (credit_cnt !== 4'd5) begin errors++; $display("FAIL cred_pre: got %0d, required 5", credit_cnt); end
    ch_req = 4'b0001; cred_ret = 1'b1;
    @(posedge clk); #1 cred_ret = 1'b0; ch_req = '0;
    @(negedge clk);
    checks++;
    if (ch_ready[0] !== 1'b1 || credit_cnt !== 4'd5) begin
      errors++;
      $display("FAIL cred_coincide: ready=%b credit=%0d, required 1 and 5", ch_ready[0], credit_cnt);
    end
    wait_idle(20, ok);
    repeat (3) begin
      @(posedge clk); #1 cred_ret = 1'b1;
      @(posedge clk); #1 cred_ret = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (credit_cnt !== 4'd8 || err_cred !== 1'b0) begin
      errors++;
      $display("FAIL cred_fill: credit=%0d err=%b, required 8 0", credit_cnt, err_cred);
    end
    @(posedge clk); #1 cred_ret = 1'b1;
    @(posedge clk); #1 cred_ret = 1'b0;
    @(negedge clk);
    checks++;
    if (credit_cnt !== 4'd8 || err_cred !== 1'b1) begin
      errors++;
      $display("FAIL cred_over: credit=%0d err=%b, required 8 1", credit_cnt, err_cred);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    do_reset();
    resp_limit = 1;
    ch_req = 4'b0001;
    wait_rdy(0, 1'b1, 10, ok);
    ch_req = '0;
    n = 0;
    while (ch_ready[0] && n < 40) begin n++; @(negedge clk); end
    checks++;
    if (n != 1 + TMO) begin errors++; $display("FAIL tmo_len: ready high %0d cycles, required %0d", n, 1 + TMO); end
    checks++;
    if (err_timeout !== 1'b1 || credit_cnt !== 4'd7) begin
      errors++;
      $display("FAIL tmo_flags: err=%b credit=%0d, required 1 7", err_timeout, credit_cnt);
    end
    resp_limit = BEATS;
    ch_req = 4'b0001;
    wait_rdy(0, 1'b1, 10, ok);
    ch_req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_idle: no regrant, required grant after abort"); end
    wait_idle(20, ok);
    checks++;
    if (eop_seen != 1 || exp_q.size() != 0 || err_timeout !== 1'b1 || credit_cnt !== 4'd6) begin
      errors++;
      $display("FAIL tmo_after: eops=%0d pending=%0d err=%b credit=%0d, required 1 0 1 6",
               eop_seen, exp_q.size(), err_timeout, credit_cnt);
    end
  endtask

  task automatic test_proto();
    bit ok;
    do_reset();
    man_en = 4'b0100;
    @(negedge clk); man_en = '0;
    checks++;
    if (err_proto !== 1'b1) begin errors++; $display("FAIL proto_idle: got %b, required 1", err_proto); end
    ch_req = 4'b0001;
    wait_rdy(0, 1'b1, 10, ok);
    man_en = 4'b0010;
    @(negedge clk); man_en = '0; ch_req = '0;
    wait_idle(20, ok);
    checks++;
    if (eop_seen != 1 || exp_q.size() != 0 || err_proto !== 1'b1) begin
      errors++;
      $display("FAIL proto_xfer: eops=%0d pending=%0d err=%b, required 1 0 1", eop_seen, exp_q.size(), err_proto);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    man_en = 4'b1000;
    @(negedge clk); man_en = '0;
    ch_req = 4'b0001;
    wait_rdy(0, 1'b1, 10, ok);
    ch_req = '0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ch_ready !== '0 || out_en !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 ||
        out_data !== '0 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL midrst_out: ready=%b en=%b sop=%b eop=%b ch=%0d data=%h, required all 0",
               ch_ready, out_en, out_sop, out_eop, out_ch, out_data);
    end
    checks++;
    if (credit_cnt !== 4'd8 || {err_proto, err_timeout, err_cred} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_state: credit=%0d err=%b, required 8 000", credit_cnt, {err_proto, err_timeout, err_cred});
    end
    exp_q.delete();
    eop_seen = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (eop_seen != 0 || credit_cnt !== 4'd8) begin
      errors++;
      $display("FAIL midrst_after: eops=%0d credit=%0d, required 0 8", eop_seen, credit_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; ch_req = '0; man_en = '0; cred_ret = 1'b0;
    for (int i = 0; i < N_CH; i++) sent[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_credit_arith();
    test_timeout();
    test_proto();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_out_arb.md
BUS_OUT_ARB -- requirements
Module: bus_out_arb

Interface
REQ-001 Parameter N_CH, default 4, number of decoder output channels sharing one write bus.
REQ-002 Parameter BUS_W, default 512, data bus width.
REQ-003 Parameter BEATS_PER_PKT, default 2, bus beats per turbo packet.
REQ-004 Parameter CREDITS, default 8, downstream packet credits available after reset.
REQ-005 Parameter TIMEOUT, default 255, maximum idle cycles in XFER before abort.
REQ-006 clk_bus  in  1  sole clock, 400 MHz bus domain.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 ch_req  in  N_CH  level; channel i holds a complete packet.
REQ-009 ch_ready  out  N_CH  bus_ready to channel i; at most one bit set.
REQ-010 ch_en  in  N_CH  beat valid from channel i.
REQ-011 ch_data  in  N_CH*BUS_W  channel i data in slice [i*BUS_W +: BUS_W].
REQ-012 out_data  out  BUS_W  forwarded beat.
REQ-013 out_en  out  1  out_data valid.
REQ-014 out_sop, out_eop  out  1 each  first and last beat of a packet.
REQ-015 out_ch  out  clog2(N_CH)  source channel of the current beat.
REQ-016 cred_ret  in  1  one-cycle pulse; downstream freed one packet slot.
REQ-017 credit_cnt  out  clog2(CREDITS+1)  available credits.
REQ-018 err_proto, err_timeout, err_cred  out  1 each  sticky error flags.

Function
REQ-019 FSM states: IDLE, XFER, GAP.
REQ-020 IDLE: when ch_req is nonzero and credit_cnt > 0, grant the round-robin winner, latch grant_idx, decrement credit, and go to XFER next cycle.
REQ-021 Round-robin search starts at last grant_idx+1 modulo N_CH; the first search after reset starts at channel 0.
REQ-022 XFER: ch_ready[grant_idx]=1 and all other ch_ready bits are 0.
REQ-023 XFER: each ch_en[grant_idx] beat is registered to out_data/out_en with exactly 1 cycle of latency; out_ch = grant_idx.
REQ-024 A beat counter counts 0..BEATS_PER_PKT-1; out_sop is set on beat 0 and out_eop on beat BEATS_PER_PKT-1.
REQ-025 After the last beat is accepted, deassert ch_ready in the same cycle as the transition to GAP.
REQ-026 GAP lasts one cycle, then returns to IDLE; this absorbs the channel's ready-to-data pipeline slack.
REQ-027 ch_en on a non-granted channel, or in IDLE/GAP, is dropped and sets err_proto.
REQ-028 XFER with no granted beat for TIMEOUT consecutive cycles: abort to GAP, set err_timeout, and do not restore the consumed credit.
REQ-029 Credit arithmetic: a grant and cred_ret in the same cycle leave the count unchanged.
REQ-030 cred_ret when credit_cnt==CREDITS: ignore the pulse, hold the count, and set err_cred.
REQ-031 Zero credits: stay in IDLE with all ch_ready low, whatever the state of ch_req.
REQ-032 ch_req dropping after grant has no effect; the packet still completes.

Reset
REQ-033 On rst_n low, asynchronously set: state IDLE, ch_ready 0, out_en/out_sop/out_eop 0, out_data 0, out_ch 0, credit_cnt CREDITS, all error flags 0, RR pointer to channel 0, beat and timeout counters 0.
REQ-034 Reset mid-XFER discards the partial packet; no out_eop is produced for it.
REQ-035 Error flags clear only on reset.

Structure
REQ-036 Package bus_arb_pkg holds the FSM state enum and the default parameter constants.
REQ-037 Sub-module rr_arb (N_CH-wide round-robin priority picker, combinational plus pointer register) is instantiated once.

Verification
REQ-038 Single channel 0 request, CREDITS=8 -> ch_ready[0] high; two beats out with sop/eop; out_ch=0; credit_cnt goes to 7; GAP lasts one cycle.
REQ-039 All 4 channels request continuously -> grant order 0,1,2,3,0; each packet exactly 2 beats; no interleaving.
REQ-040 CREDITS=2, 3 requests, no cred_ret -> two packets granted, then stall; one cred_ret pulse -> third packet granted.
REQ-041 cred_ret coincident with grant at credit_cnt=5 -> count stays 5; cred_ret at credit_cnt=8 -> err_cred=1, count stays 8.
REQ-042 Granted channel sends 1 beat then stops, TIMEOUT=16 -> abort after 16 idle cycles, err_timeout=1, FSM returns to IDLE.
REQ-043 Assert rst_n low between beats 0 and 1 -> all outputs reach reset values immediately; no eop; credit_cnt=8.
